// File: rtl/credit_arb_pkg.sv
// Shared types and helpers for the credit arbiter: FSM state encoding,
// return-vector popcount and the stall counter width.
package credit_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    localparam int STALL_W = 16;

    // Counts set bits of a return vector; callers zero-extend narrower vectors to 16 bits.
    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/credit_arbiter_rr_pick.sv
// Combinational round-robin select: lowest set request at or above ptr,
// wrapping, found by masking a doubled request vector.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] lowest;

    always_comb begin
        dbl    = {req, req};
        // The upper copy is never masked, so any request always wraps into view.
        mask   = {(2*N){1'b1}} << ptr;
        masked = dbl & mask;
        lowest = masked & (~masked + (2*N)'(1));
        onehot = lowest[N-1:0] | lowest[2*N-1:N];
        any    = |req;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/credit_arbiter.sv
// Round-robin credit pool arbiter with drain/quiesce FSM.
// Optional stall counter output enabled by defining CREDIT_ARBITER_STATS_EN.
module credit_arbiter
    import credit_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int MAX_CREDITS = 8,
    localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] ret,
    input  logic               drain,
    output logic [NUM_REQ-1:0] gnt,
    output logic [CW-1:0]      credits,
    output logic               empty,
    output logic               drain_done,
`ifdef CREDIT_ARBITER_STATS_EN
    output logic               ret_err,
    output logic [STALL_W-1:0] stall_cnt
`else
    output logic               ret_err
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Sum width covers a full pool plus up to 16 simultaneous returns.
    localparam int SW = ((CW > 5) ? CW : 5) + 1;

    arb_state_t state;
    logic [PW-1:0] ptr;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;

    logic               grant_ok;
    logic [4:0]         ret_cnt;
    logic [SW-1:0]      credit_sum;
    logic               credit_over;
    logic [CW-1:0]      credits_next;
    logic [PW-1:0]      ptr_after;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        // Drain seen this cycle pre-empts any grant decision.
        grant_ok     = (state == ST_RUN) && !drain && (credits != '0) && pick_any;
        ret_cnt      = popcount(16'(ret));
        credit_sum   = SW'(credits) - SW'(grant_ok) + SW'(ret_cnt);
        credit_over  = credit_sum > SW'(MAX_CREDITS);
        credits_next = credit_over ? CW'(MAX_CREDITS) : credit_sum[CW-1:0];
        ptr_after    = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            ptr        <= '0;
            gnt        <= '0;
            credits    <= CW'(MAX_CREDITS);
            empty      <= 1'b0;
            drain_done <= 1'b0;
            ret_err    <= 1'b0;
        end else begin
            credits <= credits_next;
            empty   <= (credits_next == '0);
            if (credit_over) begin
                ret_err <= 1'b1;
            end

            if (grant_ok) begin
                gnt <= pick_onehot;
                ptr <= ptr_after;
            end else begin
                gnt <= '0;
            end

            drain_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (drain) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (credits == CW'(MAX_CREDITS)) begin
                        state      <= ST_DONE;
                        drain_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef CREDIT_ARBITER_STATS_EN
    // Counts cycles where a request is blocked only by an exhausted pool.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (drain_done) begin
            stall_cnt <= '0;
        end else if ((state == ST_RUN) && (req != '0) && (credits == '0)
                     && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed self-checking bench for credit_arbiter (NUM_REQ=4, MAX_CREDITS=8).
module tb_credit_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ret;
    logic       drain;
    logic [3:0] gnt;
    logic [3:0] credits;
    logic       empty;
    logic       drain_done;
    logic       ret_err;
`ifdef CREDIT_ARBITER_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    credit_arbiter #(
        .NUM_REQ     (4),
        .MAX_CREDITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ret        (ret),
        .drain      (drain),
        .gnt        (gnt),
        .credits    (credits),
        .empty      (empty),
        .drain_done (drain_done),
`ifdef CREDIT_ARBITER_STATS_EN
        .ret_err    (ret_err),
        .stall_cnt  (stall_cnt)
`else
        .ret_err    (ret_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; req = 4'b0000; ret = 4'b0000; drain = 1'b0;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_credits", 32'(credits), 32'd8);
        chk("rst_empty", 32'(empty), 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        chk("rst_ret_err", 32'(ret_err), 32'd0);

        // Full rotation until the pool is exhausted
        rst = 1'b1; req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'd1 << (i % 4));
            chk("rr_credits", 32'(credits), 32'(7 - i));
        end
        chk("rr_empty", 32'(empty), 32'd1);
        tick();
        chk("exhausted_gnt", 32'(gnt), 32'd0);
        chk("exhausted_credits", 32'(credits), 32'd0);

        // Returns at zero become usable the following cycle
        req = 4'b0100; ret = 4'b0011;
        tick();
        chk("ret2_credits", 32'(credits), 32'd2);
        chk("ret2_gnt", 32'(gnt), 32'd0);
        chk("ret2_empty", 32'(empty), 32'd0);
        ret = 4'b0000;
        tick();
        chk("after_ret_gnt", 32'(gnt), 32'b0100);
        chk("after_ret_credits", 32'(credits), 32'd1);
        tick();
        chk("hold_gnt", 32'(gnt), 32'b0100);
        chk("hold_credits", 32'(credits), 32'd0);

        // Build up to 5, then grant plus return in one cycle
        req = 4'b0000; ret = 4'b1111;
        tick();
        chk("ret4_credits", 32'(credits), 32'd4);
        ret = 4'b0001;
        tick();
        chk("ret1_credits", 32'(credits), 32'd5);
        req = 4'b0001; ret = 4'b0001;
        tick();
        chk("swap_gnt", 32'(gnt), 32'b0001);
        chk("swap_credits", 32'(credits), 32'd5);
        req = 4'b0000; ret = 4'b0001;
        tick();
        chk("six_credits", 32'(credits), 32'd6);
        ret = 4'b1111;
        tick();
        chk("over_credits", 32'(credits), 32'd8);
        chk("over_ret_err", 32'(ret_err), 32'd1);
        ret = 4'b0000;
        tick();
        chk("sticky_ret_err", 32'(ret_err), 32'd1);
        chk("sticky_credits", 32'(credits), 32'd8);

        // Sparse request pattern from pointer 1
        req = 4'b1010;
        tick();
        chk("sparse_gnt0", 32'(gnt), 32'b0010);
        tick();
        chk("sparse_gnt1", 32'(gnt), 32'b1000);
        tick();
        chk("sparse_gnt2", 32'(gnt), 32'b0010);
        chk("sparse_credits", 32'(credits), 32'd5);

        // Drain with 3 credits outstanding
        req = 4'b1111; drain = 1'b1;
        tick();
        chk("drain_gnt0", 32'(gnt), 32'd0);
        chk("drain_credits0", 32'(credits), 32'd5);
        tick();
        chk("drain_gnt1", 32'(gnt), 32'd0);
        ret = 4'b0111;
        tick();
        chk("drain_refill", 32'(credits), 32'd8);
        chk("drain_not_done", 32'(drain_done), 32'd0);
        chk("drain_gnt2", 32'(gnt), 32'd0);
        ret = 4'b0000;
        tick();
        chk("drain_done_pulse", 32'(drain_done), 32'd1);
        chk("drain_done_gnt", 32'(gnt), 32'd0);
        drain = 1'b0;
        tick();
        chk("drain_done_clear", 32'(drain_done), 32'd0);
        chk("done_state_gnt", 32'(gnt), 32'd0);
        tick();
        chk("resume_gnt", 32'(gnt), 32'b0100);
        chk("resume_credits", 32'(credits), 32'd7);

        // Exhaust the pool again, then stall with requests pending
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        chk("stall_entry_credits", 32'(credits), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("stall_gnt", 32'(gnt), 32'd0);
`ifdef CREDIT_ARBITER_STATS_EN
        chk("stall_cnt10", 32'(stall_cnt), 32'd10);
`endif
        req = 4'b0000; drain = 1'b1; ret = 4'b1111;
        tick();
        chk("drain2_credits0", 32'(credits), 32'd4);
        tick();
        chk("drain2_credits1", 32'(credits), 32'd8);
        ret = 4'b0000;
        tick();
        chk("drain2_done", 32'(drain_done), 32'd1);
        drain = 1'b0;
        tick();
`ifdef CREDIT_ARBITER_STATS_EN
        chk("stall_cleared", 32'(stall_cnt), 32'd0);
`endif
        chk("drain2_done_clear", 32'(drain_done), 32'd0);

        // Reset while draining with 2 credits left
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("single_gnt", 32'(gnt), 32'b0010);
        end
        chk("single_credits", 32'(credits), 32'd2);
        req = 4'b1111; drain = 1'b1;
        tick();
        tick();
        chk("pre_reset_gnt", 32'(gnt), 32'd0);
        chk("pre_reset_credits", 32'(credits), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_credits", 32'(credits), 32'd8);
        chk("midrst_drain_done", 32'(drain_done), 32'd0);
        chk("midrst_ret_err", 32'(ret_err), 32'd0);
        drain = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        chk("postrst_gnt0", 32'(gnt), 32'b0001);
        chk("postrst_credits", 32'(credits), 32'd7);
        chk("postrst_drain_done", 32'(drain_done), 32'd0);
        tick();
        chk("postrst_gnt1", 32'(gnt), 32'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
